// File: rtl/data_pointer_unit.sv
`default_nettype none
// ============================================================================
// Module   : data_pointer_unit
// Purpose  : Execution stage for the data-side Brainfuck operations
//            (+ - > < ,). Owns the data pointer and performs read-modify-write
//            of the current cell through a synchronous data RAM with a
//            registered one-cycle read path.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH   cell width in bits
//   ADDR_WIDTH   pointer width in bits (tape holds 2^ADDR_WIDTH cells)
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake; ready only in IDLE
//   cmd_op              0 NOP, 1 ADD, 2 SUB, 3 RIGHT, 4 LEFT, 5 LOAD, 6-7 NOP
//   cmd_arg             amount for ADD/SUB, value for LOAD
//   cell_value          RAM read data passthrough (valid while cmd_ready)
//   cell_zero           cell_value == 0
//   pointer             current data pointer
//   ptr_error           sticky pointer-bounds error
//   ram_address         RAM address (equals pointer)
//   ram_data_in         RAM write data (0 when not writing)
//   ram_write           RAM write enable
//   ram_data_out        RAM registered read data
// Build option
//   DATA_POINTER_BOUNDS_EN  when defined, moves past either end of the tape
//                           hold the pointer and set ptr_error; otherwise the
//                           pointer wraps and ptr_error is tied to 0.
// ============================================================================
module data_pointer_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_arg,
  output logic [DATA_WIDTH-1:0] cell_value,
  output logic                  cell_zero,
  output logic [ADDR_WIDTH-1:0] pointer,
  output logic                  ptr_error,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_MIN = '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  // FETCH: RAM read data not yet valid for the pointer. IDLE: it is.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   pointer_q, pointer_d;
  logic                    w_accept;
  logic                    w_ptr_error;

`ifdef DATA_POINTER_BOUNDS_EN
  logic                    ptr_error_q, ptr_error_d;
`endif

  // --------------------------------------------------------------------------
  // State registers. Reset is asynchronous so that an assertion mid-cycle
  // drops cmd_ready (and therefore ram_write) immediately.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pointer_q <= '0;
    end else begin
      state_q   <= state_d;
      pointer_q <= pointer_d;
    end
  end

`ifdef DATA_POINTER_BOUNDS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_error_q <= 1'b0;
    end else begin
      ptr_error_q <= ptr_error_d;
    end
  end
  assign w_ptr_error = ptr_error_q;
`else
  assign w_ptr_error = 1'b0;
`endif

  assign w_accept = cmd_valid && (state_q == ST_IDLE);

  // --------------------------------------------------------------------------
  // Next-state and RAM control. Cell updates are written in the accept cycle
  // using the current read data; the RAM's write-through read returns the new
  // value next cycle, so arithmetic ops never leave IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pointer_d   = pointer_q;
    ram_write   = 1'b0;
    ram_data_in = '0;
`ifdef DATA_POINTER_BOUNDS_EN
    ptr_error_d = ptr_error_q;
`endif

    unique case (state_q)
      ST_FETCH: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_ADD: begin
              ram_write   = 1'b1;
              ram_data_in = ram_data_out + cmd_arg;
            end
            OP_SUB: begin
              ram_write   = 1'b1;
              ram_data_in = ram_data_out - cmd_arg;
            end
            OP_LOAD: begin
              ram_write   = 1'b1;
              ram_data_in = cmd_arg;
            end
            OP_RIGHT: begin
              // The FETCH cycle is taken even when the move is blocked so
              // command timing does not depend on the pointer value.
              state_d = ST_FETCH;
`ifdef DATA_POINTER_BOUNDS_EN
              if (pointer_q == PTR_MAX) begin
                ptr_error_d = 1'b1;
              end else begin
                pointer_d = pointer_q + PTR_ONE;
              end
`else
              pointer_d = pointer_q + PTR_ONE;
`endif
            end
            OP_LEFT: begin
              state_d = ST_FETCH;
`ifdef DATA_POINTER_BOUNDS_EN
              if (pointer_q == PTR_MIN) begin
                ptr_error_d = 1'b1;
              end else begin
                pointer_d = pointer_q - PTR_ONE;
              end
`else
              pointer_d = pointer_q - PTR_ONE;
`endif
            end
            default: begin
              // NOP and reserved opcodes: accepted without effect.
            end
          endcase
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign pointer     = pointer_q;
  assign ram_address = pointer_q;
  assign ptr_error   = w_ptr_error;
  assign cell_value  = ram_data_out;
  assign cell_zero   = (ram_data_out == '0);

endmodule

`default_nettype wire

// File: tb/tb_data_pointer_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_pointer_unit
// Purpose  : Self-checking bench for data_pointer_unit with a behavioural
//            synchronous RAM (registered read, write-through) and a tape
//            model / expected-cell scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_pointer_unit;

  localparam int DW = 8;
  localparam int AW = 15;
  localparam int TAPE = 1 << AW;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] cmd_arg = '0;
  logic [DW-1:0] cell_value;
  logic          cell_zero;
  logic [AW-1:0] pointer;
  logic          ptr_error;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_write;
  logic [DW-1:0] ram_data_out;

  int checks = 0;
  int errors = 0;

  // Independent model of the tape, pointer and sticky error.
  logic [DW-1:0] model_mem [int];
  int            model_ptr = 0;
  bit            model_err = 1'b0;
  // Expected cell values, pushed when a command is driven and popped when the
  // DUT is next in IDLE with valid read data.
  logic [DW-1:0] sb_q [$];

  logic [DW-1:0] mem [0:TAPE-1];

  always #5 clk = ~clk;

  // Synchronous RAM: registered read, write-through on write.
  always @(posedge clk) begin
    if (ram_write) mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_write ? ram_data_in : mem[ram_address];
  end

  data_pointer_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .cell_value   (cell_value),
    .cell_zero    (cell_zero),
    .pointer      (pointer),
    .ptr_error    (ptr_error),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_write    (ram_write),
    .ram_data_out (ram_data_out)
  );

  function automatic logic [DW-1:0] mget(input int a);
    return model_mem.exists(a) ? model_mem[a] : '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    logic [DW-1:0] e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("cell_value", {24'd0, cell_value}, {24'd0, e});
      check("cell_zero", {31'd0, cell_zero}, {31'd0, (e == '0)});
    end
  endtask

  // Wait (bounded) for cmd_ready at the current negedge; exp_wait < 0 = don't care.
  task automatic wait_ready(input string tag, input int exp_wait);
    int waited;
    waited = 0;
    #1;
    while (!cmd_ready && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!cmd_ready) check({tag, "_timeout"}, 32'd0, 32'd1);
    if (exp_wait >= 0) check({tag, "_wait"}, waited, exp_wait);
  endtask

  // Called at a negedge: offer a command, check the accept cycle, advance.
  task automatic step(input logic [2:0] op, input logic [DW-1:0] arg, input int exp_wait);
    logic [DW-1:0] cur, nv;
    bit wr;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    wait_ready("accept", exp_wait);
    drain();
    cur = mget(model_ptr);
    nv  = cur;
    wr  = 1'b0;
    case (op)
      OP_ADD:  begin nv = cur + arg; wr = 1'b1; end
      OP_SUB:  begin nv = cur - arg; wr = 1'b1; end
      OP_LOAD: begin nv = arg;       wr = 1'b1; end
      default: ;
    endcase
    check("ram_write", {31'd0, ram_write}, {31'd0, wr});
    check("ram_data_in", {24'd0, ram_data_in}, wr ? {24'd0, nv} : 32'd0);
    check("ram_address", {17'd0, ram_address}, model_ptr);
    if (wr) begin
      model_mem[model_ptr] = nv;
      sb_q.push_back(nv);
    end
    @(posedge clk);
    if (op == OP_RIGHT) begin
`ifdef DATA_POINTER_BOUNDS_EN
      if (model_ptr == TAPE - 1) model_err = 1'b1; else model_ptr++;
`else
      model_ptr = (model_ptr + 1) % TAPE;
`endif
    end else if (op == OP_LEFT) begin
`ifdef DATA_POINTER_BOUNDS_EN
      if (model_ptr == 0) model_err = 1'b1; else model_ptr--;
`else
      model_ptr = (model_ptr + TAPE - 1) % TAPE;
`endif
    end
    @(negedge clk);
    if (op == OP_RIGHT || op == OP_LEFT) begin
      check("fetch_ready", {31'd0, cmd_ready}, 32'd0);
      check("fetch_write", {31'd0, ram_write}, 32'd0);
      check("pointer", {17'd0, pointer}, model_ptr);
      check("ptr_error", {31'd0, ptr_error}, {31'd0, model_err});
      sb_q.push_back(mget(model_ptr));
    end
  endtask

  task automatic idle(input int exp_wait);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = '0;
    wait_ready("idle", exp_wait);
    drain();
    check("idle_write", {31'd0, ram_write}, 32'd0);
    check("idle_ptr_error", {31'd0, ptr_error}, {31'd0, model_err});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int guard;
    for (int i = 0; i < TAPE; i++) mem[i] = '0;
    mem[0] = 8'h5A;
    model_mem[0] = 8'h5A;

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_write", {31'd0, ram_write}, 32'd0);
    check("rst_data_in", {24'd0, ram_data_in}, 32'd0);
    check("rst_pointer", {17'd0, pointer}, 32'd0);
    check("rst_ptr_error", {31'd0, ptr_error}, 32'd0);

    // One FETCH cycle after release, then IDLE with the pre-filled cell.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_fetch", {31'd0, cmd_ready}, 32'd0);
    sb_q.push_back(8'h5A);
    @(negedge clk);
    #1;
    check("first_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("first_idle_pointer", {17'd0, pointer}, 32'd0);
    drain();

    // Clear the cell, then three back-to-back ADD 1 with valid held high.
    step(OP_LOAD, 8'h00, 0);
    step(OP_ADD, 8'h01, 0);
    step(OP_ADD, 8'h01, 0);
    step(OP_ADD, 8'h01, 0);
    // LOAD 1 then SUB 2 -> 0xFF.
    step(OP_LOAD, 8'h01, 0);
    step(OP_SUB, 8'h02, 0);
    idle(0);

    // RIGHT, LOAD 7, LEFT: one-cycle gap after each move.
    step(OP_RIGHT, 8'h00, 0);
    step(OP_LOAD, 8'h07, 1);
    step(OP_LEFT, 8'h00, 0);
    idle(1);
    check("tape_addr1", {24'd0, mem[1]}, 32'd7);
    check("tape_addr0", {24'd0, mem[0]}, 32'h0FF);

    // LEFT from pointer 0: wrap or bounds error depending on build.
    step(OP_LEFT, 8'h00, 0);
`ifdef DATA_POINTER_BOUNDS_EN
    check("left_at_zero_ptr", {17'd0, pointer}, 32'd0);
    check("left_at_zero_err", {31'd0, ptr_error}, 32'd1);
`else
    check("left_at_zero_ptr", {17'd0, pointer}, 32'h7FFF);
    check("left_at_zero_err", {31'd0, ptr_error}, 32'd0);
`endif
    step(OP_ADD, 8'h03, 1);
    step(3'd7, 8'h09, 0);
    step(OP_NOP, 8'h00, 0);
    idle(0);

    // Move to address 1 (wraps through 0 in the default build).
    guard = 0;
    while (model_ptr != 1 && guard < 4) begin
      step(OP_RIGHT, 8'h00, -1);
      guard++;
    end
    idle(-1);
    check("at_addr1", {17'd0, pointer}, 32'd1);

    // Reset asserted during an accepted ADD.
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_arg   = 8'h05;
    #1;
    check("pre_reset_write", {31'd0, ram_write}, 32'd1);
    check("pre_reset_data", {24'd0, ram_data_in}, 32'h0C);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_drops_write", {31'd0, ram_write}, 32'd0);
    check("reset_data_in", {24'd0, ram_data_in}, 32'd0);
    check("reset_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset_pointer", {17'd0, pointer}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = '0;
    check("no_partial_write", {24'd0, mem[1]}, 32'd7);
    rst_n = 1'b1;
    model_ptr = 0;
    model_err = 1'b0;
    sb_q.push_back(mget(0));
    idle(1);
    check("post_reset_pointer", {17'd0, pointer}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
